// File: rtl/mem_arbiter.sv
// Shares the single data memory between the CPU datapath and the host load/readback port.
// The CPU has priority; a waiting host is guaranteed a turn, and a locked host burst is capped.
module mem_arbiter #(
   parameter int DATA_W       = 28,
   parameter int ADDR_W       = 28,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_HOLD     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_lock,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_out
);

   localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {
      S_CPU  = 1'b0,
      S_HOST = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic              hostSel;

   // Memory mux and handshakes; reset forces every side effect off so a burst cut by reset never writes.
   always_comb begin
      hostSel   = (state_q == S_HOST);
      cpu_rdata = mem_out;
      mem_addr  = hostSel ? host_addr  : cpu_addr;
      mem_in    = hostSel ? host_wdata : cpu_wdata;
      mem_we    = rst_n && (hostSel ? (host_req && host_we) : (cpu_req && cpu_we));
      host_gnt  = rst_n && hostSel && host_req;
      cpu_stall = rst_n && hostSel && cpu_req;
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      hold_d  = '0;
      unique case (state_q)
         S_CPU: begin
            if (host_req && (!cpu_req || wait_q == WAIT_LAST)) begin
               state_d = S_HOST;
            end else if (host_req && cpu_req) begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_HOST: begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
            // Leaving with wait_d cleared gives a waiting CPU at least one full served cycle.
            if (!(host_req && (!cpu_req || (host_lock && hold_q < HOLD_LAST)))) begin
               state_d = S_CPU;
               hold_d  = '0;
            end
         end
         default: state_d = S_CPU;
      endcase
   end

   always_comb begin
      host_rdata_d  = host_rdata_q;
      host_rvalid_d = 1'b0;
      if (host_gnt && !host_we) begin
         host_rdata_d  = mem_out;
         host_rvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_CPU;
         wait_q        <= '0;
         hold_q        <= '0;
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         hold_q        <= hold_d;
         host_rdata_q  <= host_rdata_d;
         host_rvalid_q <= host_rvalid_d;
      end
   end

   assign host_rdata  = host_rdata_q;
   assign host_rvalid = host_rvalid_q;

endmodule
